// File: rtl/uart_console_pkg.sv
// Shared constants and drain-state type for the multi-channel line-buffered console.
package uart_console_pkg;

  localparam logic [7:0] NL_CHAR        = 8'h0A;
  localparam int         STATUS_OVF_LSB = 16;
  localparam int         MAX_CH         = 16;

  typedef enum logic {
    IDLE,
    LOCK
  } drain_state_e;

endpackage

// File: rtl/console_fifo.sv
// Per-channel byte FIFO that also tracks how many complete lines (newlines) it holds.
module console_fifo
  import uart_console_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       one_left_o,
  output logic [7:0] head_o,
  output logic       nl_pending_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, nl_q, nl_d;
  logic          push_nl, pop_nl;

  assign head_o       = mem_q[rd_ptr_q];
  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);
  assign one_left_o   = (count_q == CNT_ONE);
  assign nl_pending_o = (nl_q != '0);
  assign push_nl      = push_i && (data_i == NL_CHAR);
  assign pop_nl       = pop_i && (head_o == NL_CHAR);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    nl_d     = nl_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_i && !pop_i) count_d = count_q + CNT_ONE;
    if (!push_i && pop_i) count_d = count_q - CNT_ONE;
    if (push_nl && !pop_nl) nl_d = nl_q + CNT_ONE;
    if (!push_nl && pop_nl) nl_d = nl_q - CNT_ONE;
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nl_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nl_q     <= nl_d;
    end
  end

endmodule

// File: rtl/uart_console_mc.sv
// APB multi-channel console: per-channel line FIFOs drained round-robin one whole line at a time.
// Define UART_CONSOLE_PRINT_EN to echo every drained byte to the simulator log.
module uart_console_mc
  import uart_console_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int          NUM_CH       = 4,
  parameter int          DEPTH        = 16,
  localparam int         CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           psel_i,
  input  logic           penable_i,
  input  logic           pwrite_i,
  input  logic [31:0]    paddr_i,
  input  logic [31:0]    pwdata_i,
  output logic [31:0]    prdata_o,
  output logic           pready_o,
  output logic           pslverr_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  output logic [7:0]     tx_data_o,
  output logic [CHW-1:0] tx_ch_o
);

  logic              access, wr_access, rd_access, is_data, is_status;
  logic [31:0]       offset, status_word;
  logic [29:0]       off_word;
  logic [CHW-1:0]    ch_sel;
  logic [NUM_CH-1:0] full, empty, one_left, nl_pending, eligible;
  logic [NUM_CH-1:0] wr_hit, push, pop, ovf_set, ovf_clr, ovf_q, ovf_d;
  logic [7:0]        head [NUM_CH];
  logic [7:0]        grant_head;
  drain_state_e      state_q, state_d;
  logic [CHW-1:0]    grant_q, grant_d, last_q, last_d, next_grant, hi_idx, lo_idx;
  logic              found_hi, tx_fire, release_grant;
  logic              unused_bits;

  assign access    = psel_i && penable_i;
  assign wr_access = access && pwrite_i;
  assign rd_access = access && !pwrite_i;
  assign offset    = {paddr_i[31:2], 2'b00} - CONSOLE_ADDR;
  assign off_word  = offset[31:2];
  assign is_data   = (off_word < 30'(NUM_CH));
  assign is_status = (off_word == 30'(NUM_CH));
  assign ch_sel    = offset[CHW+1:2];

  // A full channel still accepts a write when its head is being popped in the same cycle.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign pop[c]      = (state_q == LOCK) && tx_ready_i && (grant_q == CHW'(c));
    assign wr_hit[c]   = wr_access && is_data && (ch_sel == CHW'(c));
    assign push[c]     = wr_hit[c] && (!full[c] || pop[c]);
    assign ovf_set[c]  = wr_hit[c] && full[c] && !pop[c];
    assign eligible[c] = nl_pending[c] || full[c];

    console_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push[c]),
      .pop_i        (pop[c]),
      .data_i       (pwdata_i[7:0]),
      .full_o       (full[c]),
      .empty_o      (empty[c]),
      .one_left_o   (one_left[c]),
      .head_o       (head[c]),
      .nl_pending_o (nl_pending[c])
    );
  end

  always_comb begin
    status_word = '0;
    status_word[NUM_CH-1:0] = full;
    status_word[STATUS_OVF_LSB +: NUM_CH] = ovf_q;
  end

  assign ovf_clr   = (wr_access && is_status) ? pwdata_i[STATUS_OVF_LSB +: NUM_CH] : '0;
  assign ovf_d     = (ovf_q | ovf_set) & ~ovf_clr;
  assign prdata_o  = (rd_access && is_status) ? status_word : '0;
  assign pslverr_o = access && ((!is_data && !is_status) || (|ovf_set));
  assign pready_o  = 1'b1;

  // Round-robin pick: lowest eligible channel above last, else lowest eligible overall.
  always_comb begin
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = CHW'(i);
        if (i > int'(last_q)) begin
          hi_idx   = CHW'(i);
          found_hi = 1'b1;
        end
      end
    end
    next_grant = found_hi ? hi_idx : lo_idx;
  end

  assign grant_head    = head[grant_q];
  assign tx_valid_o    = (state_q == LOCK);
  assign tx_data_o     = tx_valid_o ? grant_head : 8'h00;
  assign tx_ch_o       = grant_q;
  assign tx_fire       = tx_valid_o && tx_ready_i;
  assign release_grant = tx_fire &&
                         ((grant_head == NL_CHAR) || (one_left[grant_q] && !push[grant_q]));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          grant_d = next_grant;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (release_grant) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CHW'(NUM_CH - 1);
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign unused_bits = ^{paddr_i[1:0], pwdata_i, offset[1:0], empty};

`ifdef UART_CONSOLE_PRINT_EN
  logic print_sol_q;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      print_sol_q <= 1'b1;
    end else if (tx_fire) begin
      if (print_sol_q) $write("[ch%0d] ", grant_q);
      $write("%c", tx_data_o);
      print_sol_q <= (tx_data_o == NL_CHAR) || release_grant;
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_console_mc.sv
// Self-checking bench for uart_console_mc: directed scenarios plus random traffic against a queue-level model.
module tb_uart_console_mc;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NCH  = 4;
  localparam int          DEP  = 4;
  localparam logic [7:0]  NL   = 8'h0A;

  logic        clk_i, rst_ni;
  logic        psel_i, penable_i, pwrite_i, tx_ready_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic        pready_o, pslverr_o, tx_valid_o;
  logic [7:0]  tx_data_o;
  logic [1:0]  tx_ch_o;

  uart_console_mc #(.CONSOLE_ADDR(BASE), .NUM_CH(NCH), .DEPTH(DEP)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .pwrite_i   (pwrite_i),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .prdata_o   (prdata_o),
    .pready_o   (pready_o),
    .pslverr_o  (pslverr_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_ch_o    (tx_ch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each channel is a plain byte buffer; the drainer is "locked to a channel or not".
  logic [7:0]     mbuf [NCH][DEP];
  int             mcnt [NCH];
  logic [NCH-1:0] movf;
  bit             mlock;
  int             mch, mlast;

  logic        obs_valid, obs_err;
  logic [31:0] obs_rdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    movf  = '0;
    mlock = 1'b0;
    mch   = 0;
    mlast = NCH - 1;
  endtask

  function automatic bit hasLine(input int c);
    bit found = 1'b0;
    for (int k = 0; k < DEP; k++)
      if (k < mcnt[c] && mbuf[c][k] == NL) found = 1'b1;
    return found;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model across the rising edge.
  task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic rdy);
    int             word, c;
    bit             acc, is_dat, is_sta, full_pre, pop_now;
    logic [31:0]    exp_rdata, status_word;
    logic           exp_err;
    logic [7:0]     popped;
    logic [NCH-1:0] elig;
    bit             picked;

    psel_i = sel; penable_i = en; pwrite_i = wr;
    paddr_i = addr; pwdata_i = wdata; tx_ready_i = rdy;

    acc    = sel && en;
    word   = int'(addr >> 2) - int'(BASE >> 2);
    is_dat = (word >= 0) && (word < NCH);
    is_sta = (word == NCH);
    c      = is_dat ? word : 0;
    status_word = '0;
    for (int k = 0; k < NCH; k++) begin
      status_word[k]      = (mcnt[k] == DEP);
      status_word[16 + k] = movf[k];
    end
    pop_now   = mlock && rdy;
    full_pre  = is_dat && (mcnt[c] == DEP);
    exp_err   = acc && (!(is_dat || is_sta) || (wr && full_pre && !(pop_now && mch == c)));
    exp_rdata = (acc && !wr && is_sta) ? status_word : 32'h0;

    #1;
    checkOutput("tx_valid", tx_valid_o, mlock);
    if (mlock) begin
      checkOutput("tx_data", tx_data_o, mbuf[mch][0]);
      checkOutput("tx_ch", tx_ch_o, mch);
    end
    checkOutput("pslverr", pslverr_o, exp_err);
    checkOutput("prdata", prdata_o, exp_rdata);
    obs_valid = tx_valid_o;
    obs_err   = pslverr_o;
    obs_rdata = prdata_o;

    for (int k = 0; k < NCH; k++) elig[k] = (mcnt[k] == DEP) || hasLine(k);

    @(posedge clk_i);
    popped = 8'h00;
    if (pop_now) begin
      popped = mbuf[mch][0];
      for (int k = 0; k < DEP - 1; k++) mbuf[mch][k] = mbuf[mch][k + 1];
      mcnt[mch]--;
    end
    if (acc && wr && is_dat) begin
      if (full_pre && !(pop_now && mch == c)) movf[c] = 1'b1;
      else begin
        mbuf[c][mcnt[c]] = wdata[7:0];
        mcnt[c]++;
      end
    end
    if (acc && wr && is_sta) movf = movf & ~wdata[19:16];
    if (mlock) begin
      if (pop_now && (popped == NL || mcnt[mch] == 0)) begin
        mlock = 1'b0;
        mlast = mch;
      end
    end else begin
      picked = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        if (!picked && elig[(mlast + k) % NCH]) begin
          mch    = (mlast + k) % NCH;
          mlock  = 1'b1;
          picked = 1'b1;
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data, rdy);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data, rdy);
  endtask

  task automatic apbRead(input logic [31:0] addr, input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 32'h0, rdy);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0, rdy);
  endtask

  task automatic writeChar(input int ch, input logic [7:0] b, input logic rdy);
    apbWrite(BASE + 32'(4 * ch), {24'h0, b}, rdy);
  endtask

  task automatic randomOp();
    int          op, ch;
    logic        rdy;
    logic [7:0]  b;
    logic [31:0] addr;
    op  = $urandom_range(0, 99);
    ch  = $urandom_range(0, NCH - 1);
    rdy = ($urandom_range(0, 3) != 0);
    b   = ($urandom_range(0, 3) == 0) ? NL : 8'(8'h61 + $urandom_range(0, 25));
    if (op < 55) begin
      apbWrite(BASE + 32'(4 * ch) + 32'($urandom_range(0, 3)), {$urandom, 8'h0} | 32'(b), rdy);
    end else if (op < 65) begin
      apbRead(BASE + 32'(4 * NCH) + 32'($urandom_range(0, 3)), rdy);
    end else if (op < 72) begin
      apbWrite(BASE + 32'(4 * NCH), $urandom, rdy);
    end else if (op < 77) begin
      apbRead(BASE + 32'(4 * ch), rdy);
    end else if (op < 83) begin
      addr = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(4 * (NCH + 1 + $urandom_range(0, 10)));
      if ($urandom_range(0, 1) == 0) apbWrite(addr, $urandom, rdy);
      else apbRead(addr, rdy);
    end else begin
      idle($urandom_range(1, 3), rdy);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; tx_ready_i = 1'b0;
    modelReset();

    @(negedge clk_i);
    #1;
    checkOutput("reset_tx_valid", tx_valid_o, 1'b0);
    checkOutput("reset_tx_data", tx_data_o, 8'h00);
    checkOutput("reset_tx_ch", tx_ch_o, 2'd0);
    checkOutput("reset_pslverr", pslverr_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    apbRead(BASE + 32'(4 * NCH), 1'b0);
    checkOutput("reset_status", obs_rdata, 32'h0);

    $display("[TB] single line on channel 1");
    writeChar(1, "H", 1'b1);
    writeChar(1, "i", 1'b1);
    writeChar(1, NL, 1'b1);
    idle(1, 1'b1);
    checkOutput("nl_latency_e1", obs_valid, 1'b0);
    idle(1, 1'b1);
    checkOutput("nl_latency_e2", obs_valid, 1'b1);
    idle(6, 1'b1);

    $display("[TB] no interleave between channels 0 and 2");
    writeChar(0, "a", 1'b1);
    writeChar(0, "b", 1'b1);
    writeChar(2, "x", 1'b1);
    writeChar(2, "y", 1'b1);
    writeChar(2, NL, 1'b1);
    writeChar(0, NL, 1'b1);
    idle(12, 1'b1);

    $display("[TB] overflow on channel 3");
    for (int i = 0; i < 4; i++) begin
      writeChar(3, "A", 1'b0);
      checkOutput("fill_no_err", obs_err, 1'b0);
    end
    writeChar(3, "A", 1'b0);
    checkOutput("ovf_err", obs_err, 1'b1);
    apbRead(BASE + 32'(4 * NCH), 1'b0);
    checkOutput("status_ovf", obs_rdata, 32'h0008_0008);
    apbWrite(BASE + 32'(4 * NCH), 32'h0008_0000, 1'b0);
    apbRead(BASE + 32'(4 * NCH), 1'b0);
    checkOutput("status_ovf_cleared", obs_rdata, 32'h0000_0008);

    $display("[TB] full channel without newline drains");
    idle(8, 1'b1);
    apbRead(BASE + 32'(4 * NCH), 1'b1);
    checkOutput("status_drained", obs_rdata, 32'h0);

    $display("[TB] backpressure and fairness");
    writeChar(0, "p", 1'b0);
    writeChar(0, NL, 1'b0);
    writeChar(0, "q", 1'b0);
    writeChar(0, NL, 1'b0);
    writeChar(1, "r", 1'b0);
    writeChar(1, NL, 1'b0);
    for (int i = 0; i < 24; i++) idle(1, logic'(i % 2));

    $display("[TB] reset in the middle of a line");
    writeChar(2, "a", 1'b0);
    writeChar(2, "b", 1'b0);
    writeChar(2, "c", 1'b0);
    writeChar(2, NL, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("reset_mid_valid", tx_valid_o, 1'b0);
    modelReset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    apbRead(BASE + 32'(4 * NCH), 1'b1);
    checkOutput("reset_mid_status", obs_rdata, 32'h0);
    idle(6, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) randomOp();
    idle(40, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
